// File: rtl/servo_move_controller.sv
// Servo move sequencer: frame-aligned PWM, settle period and anti-chatter lockout.
// Optional build macro SERVO_IDLE_RELAX_EN de-energizes the servo (no pulses) while idle.
module servo_move_controller #(
  parameter int unsigned PERIOD_CYC   = 1000000,
  parameter int unsigned PW_OPEN_CYC  = 50000,
  parameter int unsigned PW_CLOSE_CYC = 75000,
  parameter int unsigned MOVE_FRAMES  = 25,
  parameter int unsigned HOLD_FRAMES  = 50,
  parameter int unsigned CW           = 20
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic angle_sel_i,
  input  logic manual_en_i,
  input  logic manual_angle_i,
  output logic pwm_out_o,
  output logic cur_angle_o,
  output logic busy_o,
  output logic move_done_o
);

  localparam int unsigned MaxFrames = (MOVE_FRAMES > HOLD_FRAMES) ? MOVE_FRAMES : HOLD_FRAMES;
  localparam int unsigned FlW       = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMoving = 2'd1,
    StHold   = 2'd2
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  frame_cnt_q;
  logic [CW-1:0]  pw_reg_q;
  logic [FlW-1:0] frames_left_q;
  logic           cur_angle_q;
  logic           pwm_q;
  logic           busy_q;
  logic           move_done_q;

  logic target;
  logic frame_end;
  logic pulse_on;

  function automatic logic [CW-1:0] width_of(input logic angle);
    return angle ? CW'(PW_CLOSE_CYC) : CW'(PW_OPEN_CYC);
  endfunction

  assign target    = manual_en_i ? manual_angle_i : angle_sel_i;
  assign frame_end = (frame_cnt_q == CW'(PERIOD_CYC - 1));

`ifdef SERVO_IDLE_RELAX_EN
  assign pulse_on = ((state_q == StMoving) || (state_q == StHold)) && (frame_cnt_q < pw_reg_q);
`else
  assign pulse_on = (frame_cnt_q < pw_reg_q);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      frame_cnt_q   <= '0;
      frames_left_q <= '0;
      cur_angle_q   <= 1'b0;
      pw_reg_q      <= CW'(PW_OPEN_CYC);
      pwm_q         <= 1'b0;
      busy_q        <= 1'b0;
      move_done_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_end ? '0 : frame_cnt_q + 1'b1;
      pwm_q       <= pulse_on;
      move_done_q <= 1'b0;
      // Every decision waits for the frame end so the pulse width never changes mid-pulse.
      case (state_q)
        StIdle: begin
          if (frame_end && (target != cur_angle_q)) begin
            state_q       <= StMoving;
            cur_angle_q   <= target;
            pw_reg_q      <= width_of(target);
            frames_left_q <= FlW'(MOVE_FRAMES - 1);
            busy_q        <= 1'b1;
          end
        end
        StMoving: begin
          if (frame_end) begin
            if (frames_left_q == '0) begin
              state_q       <= StHold;
              move_done_q   <= 1'b1;
              frames_left_q <= FlW'(HOLD_FRAMES - 1);
            end else begin
              frames_left_q <= frames_left_q - 1'b1;
            end
          end
        end
        StHold: begin
          if (frame_end) begin
            if (frames_left_q == '0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              frames_left_q <= frames_left_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out_o   = pwm_q;
  assign cur_angle_o = cur_angle_q;
  assign busy_o      = busy_q;
  assign move_done_o = move_done_q;

endmodule

// File: tb/tb_servo_move_controller.sv
// Scoreboard bench: a frame-level model pushes one expected record per PWM frame,
// a monitor measures each frame of DUT output and compares.
module tb_servo_move_controller;

  localparam int PERIOD = 100;
  localparam int PW_OPN = 5;
  localparam int PW_CLS = 10;
  localparam int MOVE   = 2;
  localparam int HOLD   = 3;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic angle_sel_i = 1'b0;
  logic manual_en_i = 1'b0;
  logic manual_angle_i = 1'b0;
  logic pwm_out_o, cur_angle_o, busy_o, move_done_o;

  servo_move_controller #(
    .PERIOD_CYC  (PERIOD),
    .PW_OPEN_CYC (PW_OPN),
    .PW_CLOSE_CYC(PW_CLS),
    .MOVE_FRAMES (MOVE),
    .HOLD_FRAMES (HOLD),
    .CW          (8)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .angle_sel_i   (angle_sel_i),
    .manual_en_i   (manual_en_i),
    .manual_angle_i(manual_angle_i),
    .pwm_out_o     (pwm_out_o),
    .cur_angle_o   (cur_angle_o),
    .busy_o        (busy_o),
    .move_done_o   (move_done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    int pw;
    int first;
    int busy;
    int cur;
    int done;
  } frame_t;

  frame_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit running = 1'b0;

  // Model state: a move decided at the end of frame k occupies frames m_start..m_end.
  int m_angle, m_start, m_end;

  always @(posedge clk_i) begin
    if (reset_i) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s frame=%0d got=%0d want=%0d", name, cyc / PERIOD, act, exp);
    end
  endtask

  function automatic frame_t expect_frame(input int j);
    frame_t f;
    int width;
    width  = (m_angle != 0) ? PW_CLS : PW_OPN;
    f.busy = (j >= m_start && j <= m_end) ? 1 : 0;
    f.cur  = m_angle;
    f.done = (j == m_start + MOVE) ? 1 : 0;
`ifdef SERVO_IDLE_RELAX_EN
    f.pw   = (f.busy != 0) ? width : 0;
`else
    f.pw   = width;
`endif
    f.first = (f.pw > 0) ? 1 : -1;
    return f;
  endfunction

  function automatic bit model_busy(input int k);
    return (k >= m_start && k <= m_end);
  endfunction

  // Reference model: decide at each frame end, publish the next frame's expectation.
  int mk, mtgt;
  initial forever begin
    @(negedge clk_i);
    if (running && (cyc % PERIOD) == PERIOD - 1) begin
      mk   = cyc / PERIOD;
      mtgt = manual_en_i ? int'(manual_angle_i) : int'(angle_sel_i);
      if (!model_busy(mk) && mtgt != m_angle) begin
        m_angle = mtgt;
        m_start = mk + 1;
        m_end   = mk + MOVE + HOLD;
      end
      sb.push_back(expect_frame(mk + 1));
    end
  end

  // Monitor: measure one frame of outputs, then pop and compare.
  int off, hi_cnt, first_hi, b0, c0, b_bad, c_bad, d0, d_oth;
  frame_t e;
  initial forever begin
    @(negedge clk_i);
    if (running) begin
      off = cyc % PERIOD;
      if (off == 0) begin
        hi_cnt = 0; first_hi = -1; b_bad = 0; c_bad = 0; d0 = 0; d_oth = 0;
        b0 = int'(busy_o); c0 = int'(cur_angle_o);
      end
      if (pwm_out_o === 1'b1) begin
        if (first_hi < 0) first_hi = off;
        hi_cnt++;
      end
      if (int'(busy_o) !== b0) b_bad = 1;
      if (int'(cur_angle_o) !== c0) c_bad = 1;
      if (move_done_o === 1'b1) begin
        if (off == 0) d0++;
        else d_oth++;
      end
      if (off == PERIOD - 1) begin
        if (sb.size() == 0) begin
          check("sb_empty", 0, 1);
        end else begin
          e = sb.pop_front();
          check("pwm_high_cycles", hi_cnt, e.pw);
          check("pwm_first_high", first_hi, e.first);
          check("busy", b_bad ? 2 : b0, e.busy);
          check("cur_angle", c_bad ? 2 : c0, e.cur);
          check("move_done", d0 + 2 * d_oth, e.done);
        end
      end
    end
  end

  task automatic model_init();
    m_angle = 0;
    m_start = -1000;
    m_end   = -1000;
    sb.delete();
    sb.push_back(expect_frame(0));
  endtask

  task automatic do_reset(input int n);
    running = 1'b0;
    reset_i = 1'b1;
    angle_sel_i = 1'b0;
    manual_en_i = 1'b0;
    manual_angle_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1 reset_i = 1'b0;
    model_init();
    running = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // which=0: wait for a HOLD frame at offset 50; which=1: a MOVING frame at offset 40.
  task automatic wait_for(input int which, input int budget);
    bit ok;
    int k, o;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk_i);
      #1;
      k = cyc / PERIOD;
      o = cyc % PERIOD;
      if (which == 0) ok = (k >= m_start + MOVE && k <= m_end && o == 50);
      else ok = (k >= m_start && k < m_start + MOVE && o == 40);
    end
    check(which == 0 ? "wait_hold" : "wait_moving", int'(ok), 1);
  endtask

  initial begin
    do_reset(3);
    run_cycles(3 * PERIOD);

    run_cycles(37);
    angle_sel_i = 1'b1;
    wait_for(0, 2000);
    angle_sel_i = 1'b0;
    run_cycles(15 * PERIOD);

    manual_en_i = 1'b1;
    manual_angle_i = 1'b1;
    run_cycles(8 * PERIOD);
    manual_en_i = 1'b0;
    run_cycles(15 * PERIOD);

    repeat (40 * PERIOD) begin
      @(posedge clk_i);
      #1;
      if ($urandom_range(99, 0) < 3) begin
        case ($urandom_range(2, 0))
          0: angle_sel_i = ~angle_sel_i;
          1: manual_en_i = ~manual_en_i;
          default: manual_angle_i = ~manual_angle_i;
        endcase
      end
    end

    manual_en_i = 1'b0;
    angle_sel_i = (m_angle != 0) ? 1'b0 : 1'b1;
    wait_for(1, 30 * PERIOD);
    // Single-cycle reset mid-frame during a move; frame 0 of the new run checks the restart.
    running = 1'b0;
    reset_i = 1'b1;
    angle_sel_i = 1'b0;
    manual_en_i = 1'b0;
    manual_angle_i = 1'b0;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    model_init();
    running = 1'b1;
    run_cycles(4 * PERIOD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_move_controller.md
Name: servo_move_controller

Overview:
- Sequences the single crop-cover servo from the 1-bit angle command produced by the rain/soil FSM.
- Arbitrates that command against a manual override. Manual wins whenever enabled.
- Generates the frame-aligned servo PWM, enforces a settle period and an anti-chatter lockout, and reports busy and move completion.
- Sits between the irrigation FSM and the servo pin.

Parameters:
- PERIOD_CYC, 1000000, clock cycles per PWM frame (20 ms at 50 MHz).
- PW_OPEN_CYC, 50000, pulse width for angle 0 / open (1 ms).
- PW_CLOSE_CYC, 75000, pulse width for angle 1 / closed (1.5 ms, 90°).
- MOVE_FRAMES, 25, frames of the new pulse before a move counts as settled. Must be >= 1.
- HOLD_FRAMES, 50, lockout frames after settling, during which command changes are ignored. Must be >= 1.
- CW, 20, width of the frame counter. Must satisfy 2^CW >= PERIOD_CYC.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- angle_sel  in  1  automatic command from the FSM: 0 open, 1 close
- manual_en  in  1  when 1, manual_angle overrides angle_sel
- manual_angle  in  1  manual command: 0 open, 1 close
- pwm_out  out  1  registered servo PWM
- cur_angle  out  1  angle currently commanded to the servo
- busy  out  1  high while in MOVING or HOLD
- move_done  out  1  one-cycle pulse when a move has settled

Behaviour:
- Reset values (synchronous):
  - state=IDLE, frame_cnt=0, frames_left=0.
  - cur_angle=0, pw_reg=PW_OPEN_CYC.
  - pwm_out=0, busy=0, move_done=0.
- Target selection (combinational): target = manual_en ? manual_angle : angle_sel.
- Frame counter:
  - frame_cnt runs freely 0..PERIOD_CYC-1, then wraps to 0.
  - Frame end (FE) is the cycle with frame_cnt == PERIOD_CYC-1.
- PWM output:
  - pwm_out <= (frame_cnt < pw_reg), registered, so it lags frame_cnt by one cycle.
  - Each frame therefore produces exactly pw_reg high cycles.
  - pw_reg changes only at FE, so pulses are never truncated or stretched.
- All state decisions are taken only at FE. Inputs are sampled in the FE cycle; input changes between FEs have no effect until the next FE.
- IDLE:
  - At FE, if target != cur_angle: go to MOVING; cur_angle <= target; pw_reg <= width(target); frames_left <= MOVE_FRAMES-1; busy <= 1.
  - Otherwise stay in IDLE.
- MOVING:
  - At FE, if frames_left == 0: go to HOLD; move_done <= 1 for exactly one cycle; frames_left <= HOLD_FRAMES-1.
  - Otherwise frames_left decrements.
- HOLD:
  - At FE, if frames_left == 0: go to IDLE; busy <= 0.
  - Otherwise frames_left decrements.
- Illegal state encoding: go to IDLE at the next clock.
- Target changes during MOVING or HOLD (including a toggle back) are ignored. The target is re-evaluated at the first FE spent in IDLE, so any pending difference starts a new move one frame after busy falls.
- Latency: a target change sampled at FE(n) gives the new pulse width in frame n+1. busy rises in the FE+1 cycle. move_done occurs MOVE_FRAMES frames later.
- manual_en toggling is treated as an ordinary target change. There is no extra priority pre-emption of an active move.
- Reset asserted mid-move or mid-frame: on the next clock all state returns to the reset values and the frame restarts at frame_cnt=0.

Optional Feature:
- Macro: SERVO_IDLE_RELAX_EN.
- Defined: in IDLE, pwm_out is forced to 0 (servo de-energized). Pulses are generated only in MOVING and HOLD, starting with the frame after the FE that enters MOVING.
- Undefined: pulses of width pw_reg continue in every frame, including IDLE.
- Counters, busy, move_done and cur_angle behave identically in both builds.

Test Plan (bench parameters: PERIOD_CYC=100, PW_OPEN_CYC=5, PW_CLOSE_CYC=10, MOVE_FRAMES=2, HOLD_FRAMES=3, CW=8):
- Reset then idle, angle_sel=0 -> 5-cycle pulses every 100 cycles; cur_angle=0; busy=0; move_done never pulses.
- angle_sel 0->1 mid-frame -> unchanged 5-cycle pulse until FE; then 10-cycle pulses; busy=1; move_done pulses once after 2 frames; busy drops 3 frames later; cur_angle=1.
- During HOLD, angle_sel 1->0 -> no width change until the FE after busy falls; one frame later a new move to 0 starts (5-cycle pulses).
- manual_en=1, manual_angle=1 while angle_sel=0 -> moves to close; clearing manual_en with angle_sel=0 -> moves back to open after the lockout.
- Reset asserted at frame_cnt=40 in MOVING -> next cycle pwm_out=0, busy=0, cur_angle=0, frame_cnt=0.
- SERVO_IDLE_RELAX_EN defined, angle 0->1 -> pwm_out flat in IDLE; ten-cycle pulses for exactly 5 frames; flat again after busy falls.
